// File: rtl/freecell_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freecell_pkg
// Description : Shared types and constants for the FreeCell move feeder:
//               location encoding, card constants, feeder states, move record.
// Revision    : 1.0 - initial release
// ============================================================================
package freecell_pkg;

    // Location classes in the upper two bits of a 4-bit location code
    localparam logic [1:0] LOC_FREE = 2'b10;
    localparam logic [1:0] LOC_HOME = 2'b11;

    // A home source is never legal to the player, so C/C never commits
    localparam logic [3:0] MOVE_NOP = 4'hC;

    // Suits
    localparam logic [1:0] SUIT_S = 2'd0;
    localparam logic [1:0] SUIT_C = 2'd1;
    localparam logic [1:0] SUIT_H = 2'd2;
    localparam logic [1:0] SUIT_D = 2'd3;

    // Ranks
    localparam logic [3:0] RANK_ACE   = 4'd1;
    localparam logic [3:0] RANK_TWO   = 4'd2;
    localparam logic [3:0] RANK_THREE = 4'd3;
    localparam logic [3:0] RANK_FOUR  = 4'd4;
    localparam logic [3:0] RANK_FIVE  = 4'd5;
    localparam logic [3:0] RANK_SIX   = 4'd6;
    localparam logic [3:0] RANK_SEVEN = 4'd7;
    localparam logic [3:0] RANK_EIGHT = 4'd8;
    localparam logic [3:0] RANK_NINE  = 4'd9;
    localparam logic [3:0] RANK_TEN   = 4'd10;
    localparam logic [3:0] RANK_JACK  = 4'd11;
    localparam logic [3:0] RANK_QUEEN = 4'd12;
    localparam logic [3:0] RANK_KING  = 4'd13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] dst;
    } move_t;

    // True when a location code refers to a home pile
    function automatic logic is_home(input logic [3:0] loc);
        return (loc[3:2] == LOC_HOME);
    endfunction

endpackage : freecell_pkg
`default_nettype wire

// File: rtl/freecell_move_buffer.sv
`default_nettype none
// ============================================================================
// Module      : freecell_move_buffer
// Description : DEPTH x 8 move store with write pointer, read position and
//               fill count. Reads are combinational from the read position;
//               a write landing on an empty buffer is forwarded to the read
//               port so a same-cycle load can be played immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module freecell_move_buffer
    import freecell_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  i_clr,
    input  logic  i_wr_en,
    input  move_t i_wr_data,
    input  logic  i_rd_adv,
    output move_t o_rd_data,
    output logic  o_full,
    output logic  o_empty,
    output logic  o_rd_done
);

    move_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_rd_cnt;

    logic           w_wr;
    logic           w_rd;
    logic           w_fwd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_done = (r_rd_cnt == r_count);

    assign w_wr  = i_wr_en & ~o_full;
    assign w_fwd = o_rd_done & w_wr;
    // Reading never runs past the stored entries (plus a forwarded write)
    assign w_rd  = i_rd_adv & (~o_rd_done | w_wr);

    assign o_rd_data = w_fwd ? i_wr_data : r_mem[r_rd_cnt[AW-1:0]];

    // Storage array; contents are intentionally left uninitialised on reset
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and count bookkeeping
    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
            end
            if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

endmodule : freecell_move_buffer
`default_nettype wire

// File: rtl/freecell_move_feeder.sv
`default_nettype none
// ============================================================================
// Module      : freecell_move_feeder
// Description : Replays a host-loaded list of moves into the FreeCell player
//               one move per issue slot, stopping early on win or abort, and
//               reports the outcome and the number of moves presented.
// Revision    : 1.0 - initial release
// ============================================================================
module freecell_move_feeder
    import freecell_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int PACE  = 1,
    localparam int IW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [7:0]    load_move,
    output logic          load_ready,
    input  logic          start,
    input  logic          abort,
    input  logic          clear,
    input  logic          win,
    output logic [3:0]    source,
    output logic [3:0]    dest,
    output logic          busy,
    output logic          done,
    output logic          won,
    output logic [IW-1:0] issued
);

    localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;

    feeder_state_t  r_state;
    feeder_state_t  w_state_next;

    logic [3:0]     r_source;
    logic [3:0]     r_dest;
    logic           r_busy;
    logic           r_done;
    logic           r_won;
    logic [IW-1:0]  r_issued;
    logic [PW-1:0]  r_pace;

    logic [3:0]     w_source_next;
    logic [3:0]     w_dest_next;
    logic           w_won_next;
    logic [IW-1:0]  w_issued_next;
    logic [IW-1:0]  w_issued_inc;
    logic [PW-1:0]  w_pace_next;
    logic           w_slot_end;

    logic           w_load_fire;
    logic           w_rd_adv;
    logic           w_buf_clr;
    move_t          w_rd_data;
    logic           w_full;
    logic           w_empty;
    logic           w_rd_done;

    assign load_ready  = (r_state == IDLE) & ~w_full;
    assign w_load_fire = load_valid & load_ready;
    assign w_slot_end  = (r_pace == PW'(PACE - 1));
    assign w_issued_inc = (r_issued == IW'(DEPTH)) ? r_issued : r_issued + 1'b1;

    freecell_move_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clock     (clock),
        .reset     (reset),
        .i_clr     (w_buf_clr),
        .i_wr_en   (w_load_fire),
        .i_wr_data (move_t'(load_move)),
        .i_rd_adv  (w_rd_adv),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_rd_done (w_rd_done)
    );

    // Next-state and next-output decode; win outranks abort outranks progress
    always_comb begin
        w_state_next  = r_state;
        w_source_next = MOVE_NOP;
        w_dest_next   = MOVE_NOP;
        w_won_next    = r_won;
        w_issued_next = r_issued;
        w_pace_next   = r_pace;
        w_rd_adv      = 1'b0;
        w_buf_clr     = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (!w_empty || w_load_fire) begin
                        // First slot boundary coincides with the start edge
                        w_state_next  = PLAY;
                        w_source_next = w_rd_data.src;
                        w_dest_next   = w_rd_data.dst;
                        w_rd_adv      = 1'b1;
                        w_issued_next = IW'(1);
                        w_pace_next   = '0;
                    end else begin
                        w_state_next  = DONE;
                        w_won_next    = win;
                        w_issued_next = '0;
                    end
                end
            end

            PLAY: begin
                if (win) begin
                    w_state_next = DONE;
                    w_won_next   = 1'b1;
                end else if (abort) begin
                    w_state_next = DONE;
                    w_won_next   = win;
                end else if (w_slot_end) begin
                    if (w_rd_done) begin
                        w_state_next = SETTLE;
                    end else begin
                        w_source_next = w_rd_data.src;
                        w_dest_next   = w_rd_data.dst;
                        w_rd_adv      = 1'b1;
                        w_issued_next = w_issued_inc;
                        w_pace_next   = '0;
                    end
                end else begin
                    w_pace_next = r_pace + 1'b1;
                end
            end

            // One NOP cycle lets the player commit the final move
            SETTLE: begin
                w_state_next = DONE;
                w_won_next   = win;
            end

            DONE: begin
                if (clear) begin
                    w_state_next  = IDLE;
                    w_buf_clr     = 1'b1;
                    w_issued_next = '0;
                    w_won_next    = 1'b0;
                    w_pace_next   = '0;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered outputs and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_source <= MOVE_NOP;
            r_dest   <= MOVE_NOP;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_won    <= 1'b0;
            r_issued <= '0;
            r_pace   <= '0;
        end else begin
            r_source <= w_source_next;
            r_dest   <= w_dest_next;
            r_busy   <= (w_state_next == PLAY) || (w_state_next == SETTLE);
            r_done   <= (w_state_next == DONE);
            r_won    <= w_won_next;
            r_issued <= w_issued_next;
            r_pace   <= w_pace_next;
        end
    end

    assign source = r_source;
    assign dest   = r_dest;
    assign busy   = r_busy;
    assign done   = r_done;
    assign won    = r_won;
    assign issued = r_issued;

endmodule : freecell_move_feeder
`default_nettype wire

// File: tb/tb_freecell_move_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_freecell_move_feeder
// Description : Self-checking bench for freecell_move_feeder. Two instances
//               (DEPTH=4 with PACE=1 and PACE=3) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freecell_move_feeder;

    localparam logic [3:0] c_nop = 4'hC;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_move;
    logic       start;
    logic       abort;
    logic       clear;
    logic       win;

    logic       lr1, busy1, done1, won1;
    logic [3:0] src1, dst1;
    logic [2:0] iss1;
    logic       lr3, busy3, done3, won3;
    logic [3:0] src3, dst3;
    logic [2:0] iss3;

    logic [14:0] a1;
    logic [14:0] a3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    freecell_move_feeder #(.DEPTH(4), .PACE(1)) u_p1 (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_move(load_move),
        .load_ready(lr1), .start(start), .abort(abort), .clear(clear), .win(win),
        .source(src1), .dest(dst1), .busy(busy1), .done(done1), .won(won1), .issued(iss1)
    );

    freecell_move_feeder #(.DEPTH(4), .PACE(3)) u_p3 (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_move(load_move),
        .load_ready(lr3), .start(start), .abort(abort), .clear(clear), .win(win),
        .source(src3), .dest(dst3), .busy(busy3), .done(done3), .won(won3), .issued(iss3)
    );

    assign a1 = {src1, dst1, busy1, done1, won1, lr1, iss1};
    assign a3 = {src3, dst3, busy3, done3, won3, lr3, iss3};

    // Expected output word: {source, dest, busy, done, won, load_ready, issued}
    function automatic logic [14:0] E(input logic [3:0] s, input logic [3:0] d,
                                      input logic b, input logic dn, input logic w,
                                      input logic lr, input int iss);
        logic [2:0] v;
        v = iss[2:0];
        return {s, d, b, dn, w, lr, v};
    endfunction

    typedef struct {
        logic        lv;
        logic [7:0]  mv;
        logic        st, ab, cl, w;
        logic        c1, c3;
        logic [14:0] e1, e3;
    } vec_t;

    function automatic vec_t V(input logic lv, input logic [7:0] mv, input logic st,
                               input logic ab, input logic cl, input logic w,
                               input logic c1, input logic c3,
                               input logic [14:0] e1, input logic [14:0] e3);
        vec_t r;
        r.lv = lv; r.mv = mv; r.st = st; r.ab = ab; r.cl = cl; r.w = w;
        r.c1 = c1; r.c3 = c3; r.e1 = e1; r.e3 = e3;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic lv, input logic [7:0] mv, input logic st,
                        input logic ab, input logic cl, input logic w);
        load_valid = lv; load_move = mv; start = st; abort = ab; clear = cl; win = w;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] mv);
        step(1'b1, mv, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl[21];
    logic [14:0] c_idle, c_d2, c_z;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        c_idle = E(c_nop, c_nop, 0, 0, 0, 1, 0);
        c_d2   = E(c_nop, c_nop, 0, 1, 0, 0, 2);
        c_z    = '0;

        // Basic two-move playback on both pacings, then DEPTH=4 overflow
        tbl[0]  = V(1, 8'h0C, 0, 0, 0, 0, 1, 1, c_idle, c_idle);
        tbl[1]  = V(1, 8'h1C, 1, 0, 0, 0, 1, 1, E(4'h0, c_nop, 1, 0, 0, 0, 1), E(4'h0, c_nop, 1, 0, 0, 0, 1));
        tbl[2]  = V(0, 8'h00, 0, 0, 0, 0, 1, 1, E(4'h1, c_nop, 1, 0, 0, 0, 2), E(c_nop, c_nop, 1, 0, 0, 0, 1));
        tbl[3]  = V(0, 8'h00, 0, 0, 0, 0, 1, 1, E(c_nop, c_nop, 1, 0, 0, 0, 2), E(c_nop, c_nop, 1, 0, 0, 0, 1));
        tbl[4]  = V(0, 8'h00, 1, 0, 0, 0, 1, 1, c_d2, E(4'h1, c_nop, 1, 0, 0, 0, 2));
        tbl[5]  = V(1, 8'h77, 0, 0, 0, 0, 1, 1, c_d2, E(c_nop, c_nop, 1, 0, 0, 0, 2));
        tbl[6]  = V(0, 8'h00, 0, 0, 0, 0, 1, 1, c_d2, E(c_nop, c_nop, 1, 0, 0, 0, 2));
        tbl[7]  = V(0, 8'h00, 0, 0, 0, 0, 1, 1, c_d2, E(c_nop, c_nop, 1, 0, 0, 0, 2));
        tbl[8]  = V(0, 8'h00, 0, 0, 0, 0, 1, 1, c_d2, c_d2);
        tbl[9]  = V(0, 8'h00, 0, 0, 1, 0, 1, 1, c_idle, c_idle);
        tbl[10] = V(1, 8'h0C, 0, 0, 0, 0, 1, 1, c_idle, c_idle);
        tbl[11] = V(1, 8'h1C, 0, 0, 0, 0, 1, 1, c_idle, c_idle);
        tbl[12] = V(1, 8'h2C, 0, 0, 0, 0, 1, 1, c_idle, c_idle);
        tbl[13] = V(1, 8'h3C, 0, 0, 0, 0, 1, 1, E(c_nop, c_nop, 0, 0, 0, 0, 0), E(c_nop, c_nop, 0, 0, 0, 0, 0));
        tbl[14] = V(1, 8'h4C, 0, 0, 0, 0, 1, 1, E(c_nop, c_nop, 0, 0, 0, 0, 0), E(c_nop, c_nop, 0, 0, 0, 0, 0));
        tbl[15] = V(0, 8'h00, 1, 0, 0, 0, 1, 1, E(4'h0, c_nop, 1, 0, 0, 0, 1), E(4'h0, c_nop, 1, 0, 0, 0, 1));
        tbl[16] = V(0, 8'h00, 0, 0, 0, 0, 1, 0, E(4'h1, c_nop, 1, 0, 0, 0, 2), c_z);
        tbl[17] = V(0, 8'h00, 0, 0, 0, 0, 1, 0, E(4'h2, c_nop, 1, 0, 0, 0, 3), c_z);
        tbl[18] = V(0, 8'h00, 0, 0, 0, 0, 1, 0, E(4'h3, c_nop, 1, 0, 0, 0, 4), c_z);
        tbl[19] = V(0, 8'h00, 0, 0, 0, 0, 1, 0, E(c_nop, c_nop, 1, 0, 0, 0, 4), c_z);
        tbl[20] = V(0, 8'h00, 0, 0, 0, 0, 1, 0, E(c_nop, c_nop, 0, 1, 0, 0, 4), c_z);

        // Reset values
        reset = 1'b1;
        load_valid = 1'b0; load_move = 8'h00; start = 1'b0;
        abort = 1'b0; clear = 1'b0; win = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_p1", 32'(a1), 32'(c_idle));
        chk("reset_p3", 32'(a3), 32'(c_idle));
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].lv, tbl[i].mv, tbl[i].st, tbl[i].ab, tbl[i].cl, tbl[i].w);
            if (tbl[i].c1) chk($sformatf("vec%0d_p1", i), 32'(a1), 32'(tbl[i].e1));
            if (tbl[i].c3) chk($sformatf("vec%0d_p3", i), 32'(a3), 32'(tbl[i].e3));
        end

        // PACE=3 four-move run: 4*3+1 = 13 edges after PLAY entry, 5 already elapsed
        n = 0;
        while (!done3 && n < 40) begin
            idle_step();
            n++;
        end
        chk("p3_remaining_cycles", 32'(n), 32'd8);
        chk("p3_four_done", 32'(a3), 32'(E(c_nop, c_nop, 0, 1, 0, 0, 4)));
        step(0, 8'h00, 0, 0, 1, 0);
        chk("clear_after_four_p1", 32'(a1), 32'(c_idle));

        // Win observed after the second move
        load(8'h0C); load(8'h1C); load(8'h2C); load(8'h3C);
        step(0, 8'h00, 1, 0, 0, 0);
        idle_step();
        idle_step();
        chk("win_pre_p1", 32'(a1), 32'(E(4'h2, c_nop, 1, 0, 0, 0, 3)));
        step(0, 8'h00, 0, 0, 0, 1);
        chk("win_p1", 32'(a1), 32'(E(c_nop, c_nop, 0, 1, 1, 0, 3)));
        chk("win_p3", 32'(a3), 32'(E(c_nop, c_nop, 0, 1, 1, 0, 1)));
        idle_step();
        chk("win_hold_p1", 32'(a1), 32'(E(c_nop, c_nop, 0, 1, 1, 0, 3)));
        step(0, 8'h00, 0, 0, 1, 0);
        chk("win_clear_p1", 32'(a1), 32'(c_idle));

        // Abort mid-play, then clear and an empty start
        load(8'h0C); load(8'h1C);
        step(0, 8'h00, 1, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        chk("abort_p1", 32'(a1), 32'(E(c_nop, c_nop, 0, 1, 0, 0, 1)));
        chk("abort_p3", 32'(a3), 32'(E(c_nop, c_nop, 0, 1, 0, 0, 1)));
        step(0, 8'h00, 0, 0, 1, 0);
        chk("abort_clear_p1", 32'(a1), 32'(c_idle));
        step(0, 8'h00, 1, 0, 0, 0);
        chk("empty_start_p1", 32'(a1), 32'(E(c_nop, c_nop, 0, 1, 0, 0, 0)));
        step(0, 8'h00, 0, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("empty_start_win_p3", 32'(a3), 32'(E(c_nop, c_nop, 0, 1, 1, 0, 0)));
        step(0, 8'h00, 0, 0, 1, 0);

        // Reset mid-play clears everything including the buffer
        load(8'h0C); load(8'h1C);
        step(0, 8'h00, 1, 0, 0, 0);
        reset = 1'b1;
        idle_step();
        reset = 1'b0;
        chk("midplay_reset_p1", 32'(a1), 32'(c_idle));
        chk("midplay_reset_p3", 32'(a3), 32'(c_idle));
        step(0, 8'h00, 1, 0, 0, 0);
        chk("post_reset_empty_p1", 32'(a1), 32'(E(c_nop, c_nop, 0, 1, 0, 0, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_freecell_move_feeder
`default_nettype wire
